tdt_dtm_apbm: RTL and testbench

TDT_DTM_APBM -- requirements
Module: tdt_dtm_apbm

---
 rtl/tdt_dtm_apbm.sv | 197 +++++++++++++++++++
 tb/tb_tdt_dtm_apbm.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdt_dtm_apbm.sv
// DMI-to-APB master bridge: one request in flight, registered APB outputs.
// Optional ACCESS-phase timeout is built when TDT_APBM_TIMEOUT_EN is defined.
module tdt_dtm_apbm #(
  parameter int DTM_ABITS = 16,
  parameter int APBM_TOUT = 255
) (
  input  logic                 tclk,
  input  logic                 trst,
  input  logic                 dmihardreset,
  input  logic                 dtm_apbm_wr_vld,
  input  logic [DTM_ABITS-1:0] dtm_apbm_wr_addr,
  input  logic [1:0]           dtm_apbm_wr_flg,
  input  logic [31:0]          dtm_apbm_wdata,
  output logic [31:0]          apbm_dtm_rdata,
  output logic                 apbm_dtm_wr_ready,
  output logic [1:0]           apbm_dtm_resp,
  output logic                 apbm_psel,
  output logic                 apbm_penable,
  output logic                 apbm_pwrite,
  output logic [DTM_ABITS-1:0] apbm_paddr,
  output logic [31:0]          apbm_pwdata,
  input  logic [31:0]          apbm_prdata,
  input  logic                 apbm_pready,
  input  logic                 apbm_pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OK   = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;
  localparam logic [1:0] RESP_BUSY = 2'd3;

  if (APBM_TOUT < 1 || APBM_TOUT > 255) begin : g_tout_chk
    $error("APBM_TOUT out of range 1..255");
  end

  state_e               state_q, state_d;
  logic                 psel_q, psel_d;
  logic                 pen_q, pen_d;
  logic                 pwrite_q, pwrite_d;
  logic [DTM_ABITS-1:0] paddr_q, paddr_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [1:0]           resp_q, resp_d;
  logic                 busy_q, busy_d;

  logic is_idle;
  logic req_ok;
  logic drop;
  logic done;
  logic tout;

  assign is_idle = (state_q == IDLE);
  assign req_ok  = dtm_apbm_wr_vld && is_idle
                && (dtm_apbm_wr_flg == 2'b01
                 || dtm_apbm_wr_flg == 2'b10);
  assign drop    = dtm_apbm_wr_vld && !is_idle;
  assign done    = (state_q == ACCESS) && apbm_pready;

`ifdef TDT_APBM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  localparam logic [7:0] TOUT_LAST = 8'(APBM_TOUT - 1);

  // Abort on the edge where the wait count would reach APBM_TOUT
  assign tout = (state_q == ACCESS) && !apbm_pready
             && (cnt_q == TOUT_LAST);

  // Wait counter: cleared entering ACCESS, counts stalled cycles
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = 8'd0;
    end else if (state_q == ACCESS && !apbm_pready) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Wait counter register
  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tout = 1'b0;
`endif

  // State register
  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; hard reset wins over everything
  always_comb begin
    state_d = state_q;
    if (dmihardreset) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_ok) state_d = SETUP;
        end
        SETUP: begin
          state_d = ACCESS;
        end
        ACCESS: begin
          if (done || tout) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output / datapath next values, registered below
  always_comb begin
    psel_d   = (state_d != IDLE);
    pen_d    = (state_d == ACCESS);
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    resp_d   = resp_q;
    busy_d   = busy_q;
    if (dmihardreset) begin
      busy_d = 1'b0;
      resp_d = RESP_OK;
    end else begin
      if (req_ok) begin
        paddr_d  = dtm_apbm_wr_addr;
        pwdata_d = dtm_apbm_wdata;
        pwrite_d = (dtm_apbm_wr_flg == 2'b10);
      end
      if (is_idle && dtm_apbm_wr_vld) begin
        if (dtm_apbm_wr_flg == 2'b00) resp_d = RESP_OK;
        if (dtm_apbm_wr_flg == 2'b11) resp_d = RESP_FAIL;
      end
      if (drop) busy_d = 1'b1;
      if (done || tout) begin
        busy_d = 1'b0;
        if (busy_q || drop) begin
          resp_d = RESP_BUSY;
        end else if (done && !apbm_pslverr) begin
          resp_d = RESP_OK;
        end else begin
          resp_d = RESP_FAIL;
        end
        if (done && !pwrite_q) rdata_d = apbm_prdata;
        if (tout) rdata_d = 32'd0;
      end
    end
  end

  // Registered outputs and sticky busy flag
  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= 32'd0;
      rdata_q  <= 32'd0;
      resp_q   <= RESP_OK;
      busy_q   <= 1'b0;
    end else begin
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      busy_q   <= busy_d;
    end
  end

  assign apbm_dtm_wr_ready = is_idle;
  assign apbm_dtm_rdata    = rdata_q;
  assign apbm_dtm_resp     = resp_q;
  assign apbm_psel         = psel_q;
  assign apbm_penable      = pen_q;
  assign apbm_pwrite       = pwrite_q;
  assign apbm_paddr        = paddr_q;
  assign apbm_pwdata       = pwdata_q;

endmodule

// File: tb/tb_tdt_dtm_apbm.sv
// Bench for tdt_dtm_apbm: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tdt_dtm_apbm;

  localparam int AW   = 16;
  localparam int TOUT = 4;

  logic          tclk = 1'b0;
  logic          trst = 1'b0;
  logic          dmihardreset = 1'b0;
  logic          vld = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [1:0]    flg = 2'b00;
  logic [31:0]   wdata = 32'd0;
  logic [31:0]   rdata;
  logic          ready;
  logic [1:0]    resp;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;

  int tests = 0;
  int fails = 0;

  // simple APB slave
  int          slv_wait = 0;
  logic        slv_hang = 1'b0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = 32'd0;
  int          acc = 0;

  assign pready  = psel && penable && !slv_hang && (acc == slv_wait);
  assign prdata  = slv_rdata;
  assign pslverr = slv_err;

  always @(posedge tclk) begin
    if (psel && penable && !pready) acc <= acc + 1;
    else acc <= 0;
  end

  always #5 tclk = ~tclk;

  tdt_dtm_apbm #(.DTM_ABITS(AW), .APBM_TOUT(TOUT)) dut (
    .tclk              (tclk),
    .trst              (trst),
    .dmihardreset      (dmihardreset),
    .dtm_apbm_wr_vld   (vld),
    .dtm_apbm_wr_addr  (addr),
    .dtm_apbm_wr_flg   (flg),
    .dtm_apbm_wdata    (wdata),
    .apbm_dtm_rdata    (rdata),
    .apbm_dtm_wr_ready (ready),
    .apbm_dtm_resp     (resp),
    .apbm_psel         (psel),
    .apbm_penable      (penable),
    .apbm_pwrite       (pwrite),
    .apbm_paddr        (paddr),
    .apbm_pwdata       (pwdata),
    .apbm_prdata       (prdata),
    .apbm_pready       (pready),
    .apbm_pslverr      (pslverr)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // transaction-level model: m_pos 0 idle, 1 setup, k+1 = k-th access
  logic          m_act = 1'b0;
  int            m_pos = 0;
  logic          m_sticky = 1'b0;
  logic [31:0]   m_rdata = 32'd0;
  logic [1:0]    m_resp = 2'd0;
  logic [AW-1:0] m_paddr = '0;
  logic [31:0]   m_pwdata = 32'd0;
  logic          m_pwrite = 1'b0;

  always @(posedge tclk or posedge trst) begin
    if (trst) begin
      m_act <= 0; m_pos <= 0; m_sticky <= 0;
      m_rdata <= 0; m_resp <= 0; m_paddr <= 0;
      m_pwdata <= 0; m_pwrite <= 0;
    end else if (dmihardreset) begin
      m_act <= 0; m_pos <= 0; m_sticky <= 0; m_resp <= 0;
    end else if (!m_act) begin
      if (vld) begin
        if (flg == 2'b00) m_resp <= 2'd0;
        else if (flg == 2'b11) m_resp <= 2'd2;
        else begin
          m_act <= 1; m_pos <= 1;
          m_paddr <= addr; m_pwdata <= wdata;
          m_pwrite <= (flg == 2'b10);
        end
      end
    end else if (m_pos == 1) begin
      m_pos <= 2;
      if (vld) m_sticky <= 1;
    end else if (pready) begin
      m_act <= 0; m_pos <= 0; m_sticky <= 0;
      m_resp <= (m_sticky || vld) ? 2'd3 : (pslverr ? 2'd2 : 2'd0);
      if (!m_pwrite) m_rdata <= prdata;
    end else begin
`ifdef TDT_APBM_TIMEOUT_EN
      if (m_pos - 1 == TOUT) begin
        m_act <= 0; m_pos <= 0; m_sticky <= 0;
        m_resp <= (m_sticky || vld) ? 2'd3 : 2'd2;
        m_rdata <= 0;
      end else begin
        m_pos <= m_pos + 1;
        if (vld) m_sticky <= 1;
      end
`else
      m_pos <= m_pos + 1;
      if (vld) m_sticky <= 1;
`endif
    end
  end

  logic chk_en = 1'b0;

  always @(negedge tclk) begin
    if (chk_en) begin
      chk("m_ready", 32'(ready), 32'(!m_act));
      chk("m_psel", 32'(psel), 32'(m_act));
      chk("m_penable", 32'(penable), 32'(m_pos >= 2));
      chk("m_pwrite", 32'(pwrite), 32'(m_pwrite));
      chk("m_paddr", 32'(paddr), 32'(m_paddr));
      chk("m_pwdata", pwdata, m_pwdata);
      chk("m_rdata", rdata, m_rdata);
      chk("m_resp", 32'(resp), 32'(m_resp));
    end
  end

  task automatic req(input logic [1:0] f, input logic [AW-1:0] a,
                     input logic [31:0] d);
    @(posedge tclk); #1;
    vld = 1; flg = f; addr = a; wdata = d;
    @(posedge tclk); #1;
    vld = 0; flg = 2'b00;
  endtask

  task automatic wait_pen(input int maxc);
    int n = 0;
    while (!penable && n < maxc) begin
      @(negedge tclk); n++;
    end
    if (!penable) chk("wait_penable", 0, 1);
  endtask

  task automatic wait_ready(input int maxc);
    int n = 0;
    while (!ready && n < maxc) begin
      @(negedge tclk); n++;
    end
    if (!ready) chk("wait_ready", 0, 1);
  endtask

  initial begin
    logic [31:0] keep;
    int cnt;
    #2 trst = 1;
    #1 chk_en = 1;
    @(negedge tclk);
    chk("rst_ready", 32'(ready), 1);
    @(negedge tclk);
    trst = 0;
    @(negedge tclk);
    chk("rst_ready_after", 32'(ready), 1);
    chk("rst_psel", 32'(psel), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", 32'(resp), 0);
    chk("rst_paddr", 32'(paddr), 0);

    // read, zero wait states
    slv_wait = 0; slv_rdata = 32'hDEADBEEF;
    @(posedge tclk); #1;
    vld = 1; flg = 2'b01; addr = 16'h0011;
    @(posedge tclk); #1;
    vld = 0; flg = 2'b00;
    @(negedge tclk);
    chk("rd_n1_psel", 32'(psel), 1);
    chk("rd_n1_pen", 32'(penable), 0);
    chk("rd_n1_paddr", 32'(paddr), 32'h0011);
    @(negedge tclk);
    chk("rd_n2_pen", 32'(penable), 1);
    @(negedge tclk);
    chk("rd_n3_ready", 32'(ready), 1);
    chk("rd_n3_rdata", rdata, 32'hDEADBEEF);
    chk("rd_n3_resp", 32'(resp), 0);

    // write, 3 wait states, slave error
    slv_wait = 3; slv_err = 1; slv_rdata = 32'h0BAD0BAD;
    req(2'b10, 16'h0042, 32'h12345678);
    cnt = 0;
    for (int i = 0; i < 20 && !ready; i++) begin
      @(negedge tclk);
      if (penable) begin
        cnt++;
        chk("wr_pwrite", 32'(pwrite), 1);
        chk("wr_pwdata", pwdata, 32'h12345678);
      end
    end
    wait_ready(2);
    chk("wr_access_cycles", cnt, 4);
    chk("wr_resp", 32'(resp), 2);
    chk("wr_rdata_kept", rdata, 32'hDEADBEEF);
    slv_err = 0;

    // overlapping request during ACCESS
    slv_wait = 2; slv_rdata = 32'h11112222;
    req(2'b01, 16'h0020, 32'd0);
    wait_pen(10);
    vld = 1; flg = 2'b01; addr = 16'h0099;
    @(negedge tclk);
    vld = 0; flg = 2'b00;
    wait_ready(10);
    chk("ovl_resp", 32'(resp), 3);
    chk("ovl_rdata", rdata, 32'h11112222);
    cnt = 0;
    repeat (3) begin
      @(negedge tclk);
      if (psel) cnt++;
    end
    chk("ovl_no_second", cnt, 0);
    slv_wait = 0; slv_rdata = 32'hCAFE0003;
    req(2'b01, 16'h0021, 32'd0);
    wait_ready(10);
    @(negedge tclk);
    chk("clean_resp", 32'(resp), 0);
    chk("clean_rdata", rdata, 32'hCAFE0003);

    // reserved / nop / reserved
    req(2'b11, 16'h0001, 32'd0);
    @(negedge tclk);
    chk("rsv_resp", 32'(resp), 2);
    chk("rsv_psel", 32'(psel), 0);
    req(2'b00, 16'h0002, 32'd0);
    @(negedge tclk);
    chk("nop_resp", 32'(resp), 0);
    chk("nop_psel", 32'(psel), 0);
    chk("nop_rdata", rdata, 32'hCAFE0003);
    req(2'b11, 16'h0003, 32'd0);
    @(negedge tclk);
    chk("rsv2_resp", 32'(resp), 2);

    // hard reset during ACCESS with simultaneous request
    slv_hang = 1;
    req(2'b10, 16'h0055, 32'hAAAA5555);
    wait_pen(10);
    keep = rdata;
    dmihardreset = 1; vld = 1; flg = 2'b01; addr = 16'h0077;
    @(negedge tclk);
    dmihardreset = 0; vld = 0; flg = 2'b00;
    chk("hr_ready", 32'(ready), 1);
    chk("hr_psel", 32'(psel), 0);
    chk("hr_pen", 32'(penable), 0);
    chk("hr_resp", 32'(resp), 0);
    chk("hr_rdata", rdata, keep);
    cnt = 0;
    repeat (3) begin
      @(negedge tclk);
      if (psel) cnt++;
    end
    chk("hr_no_new", cnt, 0);

    // stalled slave: timeout or indefinite wait
    req(2'b01, 16'h0066, 32'd0);
    wait_pen(10);
`ifdef TDT_APBM_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 50 && !ready; i++) begin
      if (penable) cnt++;
      @(negedge tclk);
    end
    wait_ready(2);
    chk("to_access_cycles", cnt, TOUT);
    chk("to_rdata", rdata, 0);
    chk("to_resp", 32'(resp), 2);
`else
    repeat (1000) @(negedge tclk);
    chk("hang_pen", 32'(penable), 1);
    chk("hang_ready", 32'(ready), 0);
    dmihardreset = 1;
    @(negedge tclk);
    dmihardreset = 0;
    chk("hang_abort", 32'(ready), 1);
`endif

    // async reset in the middle of a transfer
    slv_rdata = 32'h77778888;
    req(2'b01, 16'h0033, 32'd0);
    wait_pen(10);
    #2 trst = 1;
    #1;
    chk("mid_rst_psel", 32'(psel), 0);
    chk("mid_rst_ready", 32'(ready), 1);
    chk("mid_rst_rdata", rdata, 0);
    repeat (2) @(negedge tclk);
    #2 trst = 0;
    slv_hang = 0;
    @(negedge tclk);
    chk("post_rst_ready", 32'(ready), 1);
    chk("post_rst_resp", 32'(resp), 0);
    req(2'b01, 16'h0034, 32'd0);
    wait_ready(10);
    @(negedge tclk);
    chk("post_rst_rdata", rdata, 32'h77778888);

    repeat (2) @(negedge tclk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
